// File: rtl/gost_28147_89_gamma_pkg.sv
// Shared definitions for the GOST 28147-89 gamma (counter-mode) front-end:
// step constants, controller state encoding and the end-around-carry adder.
package gost_28147_89_gamma_pkg;

    localparam logic [31:0] C1_DEFAULT = 32'h01010104;
    localparam logic [31:0] C2_DEFAULT = 32'h01010101;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INIT      = 3'd1,
        ST_INIT_WAIT = 3'd2,
        ST_STEP      = 3'd3,
        ST_GEN       = 3'd4,
        ST_GEN_WAIT  = 3'd5,
        ST_HOLD      = 3'd6
    } gamma_state_e;

    // Addition modulo 2^32-1 in its hardware form: the carry out of bit 31
    // is folded back into bit 0.
    function automatic logic [31:0] add_end_around(input logic [31:0] a,
                                                   input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[31:0] + {31'd0, s[32]};
    endfunction

endpackage

// File: rtl/gost_28147_89.sv
// GOST 28147-89 ECB block core: one Feistel round per clock, 32 rounds per block,
// done pulses for one cycle when cdata holds the result.
module gost_28147_89 (
    input  logic         clk,
    input  logic         rst,
    input  logic         mode,
    input  logic         load,
    input  logic [255:0] key,
    input  logic [63:0]  pdata,
    output logic         done,
    output logic [63:0]  cdata
);

    // Test-parameter S-box; row i substitutes nibble i, entry j lives at bits [4j+3:4j].
    localparam logic [63:0] SBOX [8] = '{
        64'h35F7C1B6E08D29A4,
        64'h95701832AFD6C4BE,
        64'hB9067CFE243AD185,
        64'h352BC64EF9801AD7,
        64'h2B30E9A48DF517C6,
        64'hEFC95863D1270AB4,
        64'hC2867EA095F314BD,
        64'hC8B6E3294A750DF1
    };

    logic [31:0] n1_q, n1_d;
    logic [31:0] n2_q, n2_d;
    logic [4:0]  round_q, round_d;
    logic        run_q, run_d;
    logic        done_q, done_d;
    logic [2:0]  key_idx;
    logic [31:0] round_key;

    function automatic logic [31:0] round_f(input logic [31:0] x);
        logic [31:0] y;
        y = '0;
        for (int i = 0; i < 8; i++) begin
            y[4*i +: 4] = SBOX[i][{x[4*i +: 4], 2'b00} +: 4];
        end
        return {y[20:0], y[31:21]};
    endfunction

    // Encrypt: K0..K7 three times then K7..K0; decrypt: K0..K7 once then K7..K0 three times.
    always_comb begin
        key_idx = round_q[2:0];
        if (mode) begin
            if (round_q >= 5'd8) key_idx = ~round_q[2:0];
        end else begin
            if (round_q >= 5'd24) key_idx = ~round_q[2:0];
        end
        round_key = key[{key_idx, 5'b00000} +: 32];
    end

    always_comb begin
        n1_d    = n1_q;
        n2_d    = n2_q;
        round_d = round_q;
        run_d   = run_q;
        done_d  = 1'b0;
        if (load) begin
            n1_d    = pdata[31:0];
            n2_d    = pdata[63:32];
            round_d = 5'd0;
            run_d   = 1'b1;
        end else if (run_q) begin
            n1_d    = n2_q ^ round_f(n1_q + round_key);
            n2_d    = n1_q;
            round_d = round_q + 5'd1;
            if (round_q == 5'd31) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n1_q    <= '0;
            n2_q    <= '0;
            round_q <= '0;
            run_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            n1_q    <= n1_d;
            n2_q    <= n2_d;
            round_q <= round_d;
            run_q   <= run_d;
            done_q  <= done_d;
        end
    end

    // The last round leaves the halves un-swapped in the output word.
    assign cdata = {n1_q, n2_q};
    assign done  = done_q;

endmodule

// File: rtl/gost_28147_89_gamma.sv
// Counter-mode (gamma) stream front-end: seeds N3/N4 from the encrypted IV, then
// XORs each data block with the encryption of the stepped counter.
module gost_28147_89_gamma
    import gost_28147_89_gamma_pkg::*;
#(
    parameter logic [31:0] C1 = C1_DEFAULT,
    parameter logic [31:0] C2 = C2_DEFAULT
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [255:0] key,
    input  logic [63:0]  iv,
    input  logic         start,
    output logic         busy,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [63:0]  in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [63:0]  out_data
);

    // Handshake: a block moves on any cycle where valid && ready at the rising
    // edge; out_valid/out_data hold until taken, and a fresh accept may coincide
    // with the handoff of the previous block.

    gamma_state_e state_q, state_d;
    logic [255:0] key_q, key_d;
    logic [63:0]  iv_q, iv_d;
    logic [63:0]  ctr_q, ctr_d;
    logic [63:0]  gamma_q, gamma_d;
    logic         gamma_valid_q, gamma_valid_d;
    logic         out_valid_q, out_valid_d;
    logic [63:0]  out_data_q, out_data_d;

    logic         core_load;
    logic [63:0]  core_pdata;
    logic         core_done;
    logic [63:0]  core_cdata;
    logic         accept;

    assign in_ready = gamma_valid_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d       = state_q;
        key_d         = key_q;
        iv_d          = iv_q;
        ctr_d         = ctr_q;
        gamma_d       = gamma_q;
        gamma_valid_d = gamma_valid_q;
        out_valid_d   = out_valid_q;
        out_data_d    = out_data_q;
        core_load     = 1'b0;
        core_pdata    = ctr_q;

        if (out_valid_q && out_ready) out_valid_d = 1'b0;
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = in_data ^ gamma_q;
        end

        case (state_q)
            ST_IDLE: begin
                // A block still waiting downstream keeps the session busy.
                if (start && !out_valid_q) begin
                    key_d   = key;
                    iv_d    = iv;
                    state_d = ST_INIT;
                end
            end
            ST_INIT: begin
                core_load  = 1'b1;
                core_pdata = iv_q;
                state_d    = ST_INIT_WAIT;
            end
            ST_INIT_WAIT: begin
                if (core_done) begin
                    ctr_d   = core_cdata;
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                ctr_d   = {add_end_around(ctr_q[63:32], C1), ctr_q[31:0] + C2};
                state_d = ST_GEN;
            end
            ST_GEN: begin
                core_load = 1'b1;
                state_d   = ST_GEN_WAIT;
            end
            ST_GEN_WAIT: begin
                if (core_done) begin
                    gamma_d       = core_cdata;
                    gamma_valid_d = 1'b1;
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (accept) begin
                    gamma_valid_d = 1'b0;
                    state_d       = in_last ? ST_IDLE : ST_STEP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            key_q         <= '0;
            iv_q          <= '0;
            ctr_q         <= '0;
            gamma_q       <= '0;
            gamma_valid_q <= 1'b0;
            out_valid_q   <= 1'b0;
            out_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            key_q         <= key_d;
            iv_q          <= iv_d;
            ctr_q         <= ctr_d;
            gamma_q       <= gamma_d;
            gamma_valid_q <= gamma_valid_d;
            out_valid_q   <= out_valid_d;
            out_data_q    <= out_data_d;
        end
    end

    gost_28147_89 u_core (
        .clk   (clk),
        .rst   (~rst),
        .mode  (1'b0),
        .load  (core_load),
        .key   (key_q),
        .pdata (core_pdata),
        .done  (core_done),
        .cdata (core_cdata)
    );

    assign busy      = (state_q != ST_IDLE) || out_valid_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_gost_28147_89_gamma.sv
// Directed bench for the GOST 28147-89 gamma front-end: seed vector, counter
// step boundaries, round trip, backpressure and control edge cases.
module tb_gost_28147_89_gamma;
    import gost_28147_89_gamma_pkg::*;

    localparam logic [255:0] KEY_SW =
        256'h72067C99_259C0687_03C148A6_B56150E9_BF0CFFF1_59493552_CF9DFF6C_00C25EBE;
    localparam logic [63:0]  IV_SW   = 64'h92A241B7_0228F80D;
    localparam logic [63:0]  SEED_SW = 64'h89DFF7F7_7D02F907;

    // Test-parameter S-box in its published row order (value for input 0..15).
    localparam int SBOX [8][16] = '{
        '{ 4, 10,  9,  2, 13,  8,  0, 14,  6, 11,  1, 12,  7, 15,  5,  3},
        '{14, 11,  4, 12,  6, 13, 15, 10,  2,  3,  8,  1,  0,  7,  5,  9},
        '{ 5,  8,  1, 13, 10,  3,  4,  2, 14, 15, 12,  7,  6,  0,  9, 11},
        '{ 7, 13, 10,  1,  0,  8,  9, 15, 14,  4,  6, 12, 11,  2,  5,  3},
        '{ 6, 12,  7,  1,  5, 15, 13,  8,  4, 10,  9, 14,  0,  3, 11,  2},
        '{ 4, 11, 10,  0,  7,  2,  1, 13,  3,  6,  8,  5,  9, 12, 15, 14},
        '{13, 11,  4,  1,  3, 15,  5,  9,  0, 10, 14,  7,  6,  8,  2, 12},
        '{ 1, 15, 13,  0,  5,  7, 10,  4,  9,  2,  3, 14,  6, 11,  8, 12}
    };

    logic         clk;
    logic         rst;
    logic [255:0] key;
    logic [63:0]  iv;
    logic         start;
    logic         busy;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_last;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] out_log[$];
    logic [63:0] gm [4];

    gost_28147_89_gamma dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .iv        (iv),
        .start     (start),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
    );

    // ---------------- clock / watchdog ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_f(input logic [31:0] x);
        logic [31:0] y;
        for (int i = 0; i < 8; i++) y[4*i +: 4] = 4'(SBOX[i][int'(x[4*i +: 4])]);
        return (y << 11) | (y >> 21);
    endfunction

    function automatic logic [63:0] model_enc(input logic [255:0] k, input logic [63:0] b);
        logic [31:0] n1, n2, kw;
        int ki;
        n1 = b[31:0];
        n2 = b[63:32];
        for (int j = 0; j < 32; j++) begin
            ki = (j < 24) ? (j % 8) : (7 - (j % 8));
            kw = k[32*ki +: 32];
            if (j % 2 == 0) n2 = n2 ^ model_f(n1 + kw);
            else            n1 = n1 ^ model_f(n2 + kw);
        end
        return {n1, n2};
    endfunction

    function automatic logic [63:0] model_step(input logic [63:0] c);
        logic [63:0] s4;
        logic [31:0] n3;
        s4 = {32'd0, c[63:32]} + 64'h0000_0000_0101_0104;
        if (s4 > 64'h0000_0000_FFFF_FFFF) s4 = s4 - 64'h0000_0000_FFFF_FFFF;
        n3 = c[31:0] + 32'h0101_0101;
        return {s4[31:0], n3};
    endfunction

    task automatic build_gamma(input logic [255:0] k, input logic [63:0] v);
        logic [63:0] c;
        c = model_enc(k, v);
        for (int i = 0; i < 4; i++) begin
            c = model_step(c);
            gm[i] = model_enc(k, c);
        end
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            out_log.push_back(out_data);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got %h want none", out_data);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if (out_data !== e) begin
                    errors++;
                    $display("FAIL sb_data got %h want %h", out_data, e);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic pulse_start(input logic [255:0] k, input logic [63:0] v);
        @(posedge clk); #1;
        key   = k;
        iv    = v;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_state(input gamma_state_e st, input string name);
        bit hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clk);
            if (dut.state_q == st) hit = 1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s got timeout want state %0d", name, st);
        end
    endtask

    task automatic wait_core_done(input string name);
        bit hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clk);
            if (dut.core_done) hit = 1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s got timeout want core done", name);
        end
    endtask

    task automatic wait_idle(input string name);
        bit hit = 0;
        for (int n = 0; n < 300 && !hit; n++) begin
            @(negedge clk);
            if (!busy) hit = 1;
        end
        if (!hit) begin
            checks++;
            errors++;
            $display("FAIL %s got busy want idle", name);
        end
    endtask

    task automatic send_block(input logic [63:0] d, input logic l, input logic [63:0] e,
                              input string name);
        bit got = 0;
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        for (int n = 0; n < 400 && !got; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                got = 1;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s got no accept want accept", name);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL reset_out_data got %h want 0", out_data); end
        checks++; if (dut.ctr_q !== 64'd0) begin errors++; $display("FAIL reset_ctr got %h want 0", dut.ctr_q); end
        checks++; if (dut.gamma_valid_q !== 1'b0) begin errors++; $display("FAIL reset_gamma_valid got %b want 0", dut.gamma_valid_q); end
        @(posedge clk); #1 rst = 1'b1;
    endtask

    task automatic test_seed();
        in_valid = 1'b1;
        in_data  = 64'h5555_AAAA_5555_AAAA;
        pulse_start(KEY_SW, IV_SW);
        wait_state(ST_INIT, "seed_reach_init");
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL init_in_ready got %b want 0", in_ready); end
        checks++; if (busy !== 1'b1)     begin errors++; $display("FAIL init_busy got %b want 1", busy); end
        wait_core_done("seed_done");
        checks++; if (dut.core_cdata !== SEED_SW) begin errors++; $display("FAIL seed_cdata got %h want %h", dut.core_cdata, SEED_SW); end
        @(negedge clk);
        checks++; if (dut.ctr_q !== SEED_SW) begin errors++; $display("FAIL seed_ctr got %h want %h", dut.ctr_q, SEED_SW); end
        checks++; if (out_valid !== 1'b0)    begin errors++; $display("FAIL seed_no_accept got %b want 0", out_valid); end
        in_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_step(input int which, input logic [63:0] forced, input logic [63:0] want);
        pulse_start(KEY_SW, IV_SW);
        if (which == 0) force dut.core_cdata = 64'hFFFFFFFE_FFFFFFFF;
        else            force dut.core_cdata = 64'h00000000_00000000;
        wait_state(ST_STEP, "step_reach");
        checks++; if (dut.ctr_q !== forced) begin errors++; $display("FAIL step_load%0d got %h want %h", which, dut.ctr_q, forced); end
        release dut.core_cdata;
        @(negedge clk);
        checks++; if (dut.ctr_q !== want) begin errors++; $display("FAIL step_result%0d got %h want %h", which, dut.ctr_q, want); end
        do_reset();
    endtask

    task automatic test_round_trip();
        logic [63:0] plain [4];
        logic [63:0] ciph [4];
        plain[0] = 64'h0;
        plain[1] = 64'h1;
        plain[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        plain[3] = 64'h0123_4567_89AB_CDEF;
        build_gamma(KEY_SW, IV_SW);
        out_log.delete();
        pulse_start(KEY_SW, IV_SW);
        for (int i = 0; i < 4; i++) send_block(plain[i], i == 3, plain[i] ^ gm[i], "rt_enc");
        wait_idle("rt_enc_idle");
        checks++;
        if (out_log.size() != 4) begin
            errors++;
            $display("FAIL rt_enc_count got %0d want 4", out_log.size());
            for (int i = 0; i < 4; i++) ciph[i] = '0;
        end else begin
            for (int i = 0; i < 4; i++) ciph[i] = out_log[i];
        end
        checks++; if (ciph[0] !== gm[0]) begin errors++; $display("FAIL rt_zero_gamma got %h want %h", ciph[0], gm[0]); end
        out_log.delete();
        pulse_start(KEY_SW, IV_SW);
        for (int i = 0; i < 4; i++) send_block(ciph[i], i == 3, plain[i], "rt_dec");
        wait_idle("rt_dec_idle");
        checks++; if (out_log.size() != 4) begin errors++; $display("FAIL rt_dec_count got %0d want 4", out_log.size()); end
    endtask

    task automatic test_backpressure();
        logic [63:0] a, b, c;
        a = 64'hDEAD_BEEF_0000_0001;
        b = 64'h1111_2222_3333_4444;
        c = 64'hCAFE_F00D_8765_4321;
        build_gamma(KEY_SW, IV_SW);
        out_log.delete();
        out_ready = 1'b0;
        pulse_start(KEY_SW, IV_SW);
        send_block(a, 1'b0, a ^ gm[0], "bp_a");
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        in_last  = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b1 || out_data !== (a ^ gm[0])) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got %b/%h want 1/%h", n, out_valid, out_data, a ^ gm[0]);
            end
        end
        checks++; if (dut.gamma_valid_q !== 1'b1) begin errors++; $display("FAIL bp_gamma_ready got %b want 1", dut.gamma_valid_q); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
        exp_q.push_back(b ^ gm[1]);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1 || out_data !== (b ^ gm[1])) begin
            errors++;
            $display("FAIL bp_b2b got %b/%h want 1/%h", out_valid, out_data, b ^ gm[1]);
        end
        @(posedge clk); #1;
        send_block(c, 1'b1, c ^ gm[2], "bp_c");
        wait_idle("bp_idle");
        checks++; if (out_log.size() != 3) begin errors++; $display("FAIL bp_count got %0d want 3", out_log.size()); end
    endtask

    task automatic test_control();
        build_gamma(KEY_SW, IV_SW);
        pulse_start(KEY_SW, IV_SW);
        wait_state(ST_HOLD, "ctl_reach_hold");
        pulse_start(~KEY_SW, ~IV_SW);
        @(negedge clk);
        checks++; if (dut.state_q !== ST_HOLD) begin errors++; $display("FAIL ctl_start_state got %0d want %0d", dut.state_q, ST_HOLD); end
        checks++; if (dut.key_q !== KEY_SW)    begin errors++; $display("FAIL ctl_start_key got %h want %h", dut.key_q, KEY_SW); end
        checks++; if (dut.iv_q !== IV_SW)      begin errors++; $display("FAIL ctl_start_iv got %h want %h", dut.iv_q, IV_SW); end
        @(posedge clk); #1;
        send_block(64'h0, 1'b0, gm[0], "ctl_blk0");
        wait_state(ST_GEN_WAIT, "ctl_reach_gen_wait");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL abort_in_ready got %b want 0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'd0) begin errors++; $display("FAIL abort_out_data got %h want 0", out_data); end
        pulse_start(KEY_SW, IV_SW);
        wait_core_done("reseed_done");
        checks++; if (dut.core_cdata !== SEED_SW) begin errors++; $display("FAIL reseed_cdata got %h want %h", dut.core_cdata, SEED_SW); end
        @(negedge clk);
        checks++; if (dut.ctr_q !== SEED_SW) begin errors++; $display("FAIL reseed_ctr got %h want %h", dut.ctr_q, SEED_SW); end
        do_reset();
    endtask

    // ---------------- sequence / report ----------------
    initial begin
        rst       = 1'b0;
        key       = '0;
        iv        = '0;
        start     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        test_reset();
        test_seed();
        test_step(0, 64'hFFFFFFFE_FFFFFFFF, 64'h01010103_01010100);
        test_step(1, 64'h00000000_00000000, 64'h01010104_01010101);
        test_round_trip();
        test_backpressure();
        test_control();

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gost_28147_89_gamma.md
Name: gost_28147_89_gamma

Overview:
- Counter-mode ("gamma") stream front-end around the gost_28147_89 ECB core.
- Encrypts the 64-bit synchro-message (IV) once to seed the N3/N4 counter. It then steps the counter per block with the GOST constants, encrypts it through the core, and XORs the resulting gamma with 64-bit data blocks.
- Sits directly upstream of the core: it drives the core's load/pdata and consumes its done/cdata.
- Gamma mode is symmetric, so the same datapath both encrypts and decrypts.

Parameters:
- C1, 32'h01010104, constant added to N4 (mod 2^32-1).
- C2, 32'h01010101, constant added to N3 (mod 2^32).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- key  in  256  cipher key, sampled on start
- iv  in  64  synchro-message, sampled on start
- start  in  1  one-cycle pulse: latch key/iv, begin session
- busy  out  1  session active or output pending
- in_valid  in  1  input block valid
- in_ready  out  1  block accepted when in_valid && in_ready
- in_data  in  64  plaintext or ciphertext block
- in_last  in  1  marks final block of session
- out_valid  out  1  output block valid
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_data  out  64  in_data XOR gamma

Behaviour:
- Reset (rst==0 at posedge):
  - FSM goes to IDLE.
  - busy=0, in_ready=0, out_valid=0, out_data=0.
  - ctr, gamma and the key/iv registers clear.
  - gamma_valid=0.
  - Core is held reset via core rst = ~rst.
  - Reset mid-session aborts with no further output.
- Core contract:
  - core.mode tied 0 (encrypt).
  - core.key comes from the latched key register, stable for the whole session.
  - core.load is a one-cycle pulse.
  - The result is taken on the cycle core.done==1. No fixed core latency is assumed.
- Counter layout:
  - ctr[63:32]=N4, ctr[31:0]=N3.
  - ctr is fed to core.pdata unmodified; iv likewise.
- Step arithmetic:
  - N3' = N3 + C2, truncated to 32 bits.
  - N4' = N4 + C1 with end-around carry: s = N4 + C1 (33-bit); N4' = s[31:0] + s[32].
- FSM states:
  - IDLE: start=1 -> latch key, iv; busy=1; go to INIT.
  - INIT: load=1, pdata=iv -> INIT_WAIT.
  - INIT_WAIT: on done, ctr <= cdata -> STEP.
  - STEP: ctr <= stepped ctr -> GEN.
  - GEN: load=1, pdata=ctr -> GEN_WAIT.
  - GEN_WAIT: on done, gamma <= cdata, gamma_valid=1 -> HOLD.
  - HOLD: wait for input acceptance. On accept, gamma_valid=0. If in_last, go to IDLE; else go to STEP.
- Handshakes:
  - in_ready = gamma_valid && (!out_valid || out_ready), combinational.
  - On accept: out_data <= in_data ^ gamma; out_valid <= 1.
  - out_valid holds, and out_data stays stable, until out_ready.
  - The next gamma is computed while the output waits, giving one block of look-ahead buffering.
  - Output handoff and a new accept in the same cycle are allowed; out_valid stays 1 with new data.
- busy = (state != IDLE) || out_valid.
- start while busy is ignored.
- in_valid in IDLE/INIT/STEP/GEN/*_WAIT: not accepted (in_ready=0).
- Counter wrap-around is defined only by the arithmetic above; no session block limit.
- Latency: start -> first in_ready = 2 core runs + 3 cycles of overhead. Accept -> out_valid = 1 cycle.

Decomposition:
- Shared package holds:
  - C1/C2 defaults.
  - FSM state encoding (3-bit enum).
  - The end-around-carry add, as a function reusable by a later MAC block.
- One sub-module: the existing gost_28147_89 core, instantiated once and unmodified.
- Counter step and XOR stay inline.

Test Plan:
- Seed check:
  - Stimulus: key = word/byte-swapped BE5EC200_6CFF9DCF_52354959_F1FF0CBF_E95061B5_A648C103_87069C25_997C0672; iv = swapped 0DF82802_B741A292; start.
  - Required: core cdata at the first done equals swapped 07F9027D_F7F7DF89, and ctr is loaded with that value.
- Step arithmetic: force ctr={FFFFFFFE, FFFFFFFF} into STEP -> ctr becomes {01010103, 01010100}. Also {00000000, 00000000} -> {01010104, 01010101}.
- Round trip:
  - Stimulus: encrypt 4 blocks 0x0, 0x1, 0xFFFFFFFFFFFFFFFF, 0x0123456789ABCDEF (last on block 4), then re-run the same key/iv on the outputs.
  - Required: the originals are recovered, and zero-input output equals the software GOST gamma model.
- Backpressure: hold out_ready=0 for 50 cycles after block 1 -> out_data stable, in_ready=0 after the next gamma is ready, no block lost or duplicated. Then release out_ready with in_valid=1 -> back-to-back handoff plus accept in the same cycle.
- Control edges:
  - start asserted mid-session -> ignored.
  - in_valid high during INIT -> not accepted.
  - rst=0 during GEN_WAIT -> all outputs 0 next cycle; a new start then reproduces the scenario-1 seed exactly.
